universal_shift_register: RTL and testbench

Parametrised successor to the 16-bit serial-in shift register. Supports WIDTH-bit manual operations: hold, logical shift left/right, rotate left/right, arithmetic shift right, parallel load and clear. Also has an autonomous serializer mode that loads a word and shifts it out MSB-first over WIDTH cycles, with a busy/done handshake. Used between the CPU data path and bit-serial peripherals, and as a general shifter/serializer in the datapath.

---
 rtl/universal_shift_register.sv | 144 ++++++++++++++
 tb/tb_universal_shift_register.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/universal_shift_register.sv
// Purpose: WIDTH-bit universal shift register with manual ops (hold/shifts/rotates/load/clear) and an MSB-first serializer.
// Latency: every operation takes effect on the next rising clk edge; all outputs come straight from flops.
// Backpressure: none; start_i and en_i are ignored while busy_o is high, and start_i has priority over en_i when idle.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   en_i, mode_i      manual operation enable and select (0 hold,1 SHL,2 SHR,3 ROL,4 ROR,5 ASR,6 LOAD,7 CLEAR)
//   ser_l_i, ser_r_i  serial fill bits for left shifts (also serializer fill) and right shifts
//   load_i, start_i   parallel data for LOAD / serializer start
//   out_o, ser_o      register contents and its MSB (serial output)
//   busy_o, done_o    serializer active, single-cycle completion pulse
//   cnt_o             shifts since last LOAD/CLEAR/start, saturating at WIDTH
module universal_shift_register #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic [2:0]       mode_i,
  input  logic             ser_l_i,
  input  logic             ser_r_i,
  input  logic [WIDTH-1:0] load_i,
  input  logic             start_i,
  output logic [WIDTH-1:0] out_o,
  output logic             ser_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [2:0] MODE_HOLD  = 3'd0;
  localparam logic [2:0] MODE_SHL   = 3'd1;
  localparam logic [2:0] MODE_SHR   = 3'd2;
  localparam logic [2:0] MODE_ROL   = 3'd3;
  localparam logic [2:0] MODE_ROR   = 3'd4;
  localparam logic [2:0] MODE_ASR   = 3'd5;
  localparam logic [2:0] MODE_LOAD  = 3'd6;
  localparam logic [2:0] MODE_CLEAR = 3'd7;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_sat_inc;
  logic             last_shift;

  // Manual shifts count up but stick at WIDTH so cnt_o never wraps to 0.
  assign cnt_sat_inc = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
  // In SHIFT the counter started at 0, so this edge performs shift number WIDTH.
  assign last_shift  = (cnt_q == CNT_MAX - CNT_W'(1));

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      r_q     <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = SHIFT;
      SHIFT:   if (last_shift) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next register contents, counter and done pulse.
  always_comb begin
    r_d    = r_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    unique case (state_q)
      SHIFT: begin
        r_d    = {r_q[WIDTH-2:0], ser_l_i};
        cnt_d  = cnt_q + CNT_W'(1);
        done_d = last_shift;
      end
      default: begin
        if (start_i) begin
          r_d   = load_i;
          cnt_d = '0;
        end else if (en_i) begin
          case (mode_i)
            MODE_SHL: begin
              r_d   = {r_q[WIDTH-2:0], ser_l_i};
              cnt_d = cnt_sat_inc;
            end
            MODE_SHR: begin
              r_d   = {ser_r_i, r_q[WIDTH-1:1]};
              cnt_d = cnt_sat_inc;
            end
            MODE_ROL: begin
              r_d   = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
              cnt_d = cnt_sat_inc;
            end
            MODE_ROR: begin
              r_d   = {r_q[0], r_q[WIDTH-1:1]};
              cnt_d = cnt_sat_inc;
            end
            MODE_ASR: begin
              r_d   = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
              cnt_d = cnt_sat_inc;
            end
            MODE_LOAD: begin
              r_d   = load_i;
              cnt_d = '0;
            end
            MODE_CLEAR: begin
              r_d   = '0;
              cnt_d = '0;
            end
            MODE_HOLD: ;
            default: ;
          endcase
        end
      end
    endcase
  end

  assign out_o  = r_q;
  assign ser_o  = r_q[WIDTH-1];
  assign busy_o = (state_q == SHIFT);
  assign done_o = done_q;
  assign cnt_o  = cnt_q;

endmodule

// File: tb/tb_universal_shift_register.sv
module tb_universal_shift_register;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [2:0]  mode = 3'd0;
  logic        sl = 1'b0;
  logic        sr = 1'b0;
  logic [15:0] ld = 16'h0;
  logic        start = 1'b0;

  logic [15:0] out16;
  logic        ser16, busy16, done16;
  logic [4:0]  cnt16;
  logic [7:0]  out8;
  logic        ser8, busy8, done8;
  logic [3:0]  cnt8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  universal_shift_register #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .en_i(en), .mode_i(mode), .ser_l_i(sl), .ser_r_i(sr),
    .load_i(ld), .start_i(start), .out_o(out16), .ser_o(ser16), .busy_o(busy16),
    .done_o(done16), .cnt_o(cnt16)
  );

  universal_shift_register #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .en_i(en), .mode_i(mode), .ser_l_i(sl), .ser_r_i(sr),
    .load_i(ld[7:0]), .start_i(start), .out_o(out8), .ser_o(ser8), .busy_o(busy8),
    .done_o(done8), .cnt_o(cnt8)
  );

  // Reference model: register as an integer value, serializer as "shifts remaining".
  typedef struct {
    logic [63:0] r;
    int          cnt;
    int          left;
    bit          done;
  } mdl_t;

  mdl_t m16, m8;

  function automatic mdl_t mstep(mdl_t m, int w);
    mdl_t        n = m;
    logic [63:0] mask = (64'd1 << w) - 64'd1;
    logic [63:0] msb  = 64'd1 << (w - 1);
    n.done = 1'b0;
    if (reset) begin
      n.r = 64'd0; n.cnt = 0; n.left = 0;
    end else if (m.left > 0) begin
      n.r    = (m.r * 2 + 64'(sl)) & mask;
      n.cnt  = m.cnt + 1;
      n.left = m.left - 1;
      n.done = (n.left == 0);
    end else if (start) begin
      n.r = 64'(ld) & mask; n.cnt = 0; n.left = w;
    end else if (en) begin
      if (mode >= 3'd1 && mode <= 3'd5) n.cnt = (m.cnt + 1 > w) ? w : m.cnt + 1;
      case (mode)
        3'd1: n.r = (m.r * 2 + 64'(sl)) & mask;
        3'd2: n.r = (m.r / 2) + (sr ? msb : 64'd0);
        3'd3: n.r = (m.r * 2 + ((m.r & msb) != 0 ? 64'd1 : 64'd0)) & mask;
        3'd4: n.r = (m.r / 2) + (m.r[0] ? msb : 64'd0);
        3'd5: n.r = (m.r / 2) + (m.r & msb);
        3'd6: begin n.r = 64'(ld) & mask; n.cnt = 0; end
        3'd7: begin n.r = 64'd0; n.cnt = 0; end
        default: ;
      endcase
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: advance model with the inputs applied, then compare all outputs.
  task automatic cyc();
    @(posedge clk);
    m16 = mstep(m16, 16);
    m8  = mstep(m8, 8);
    #1;
    chk("out16",  64'(out16),  m16.r);
    chk("ser16",  64'(ser16),  64'(m16.r[15]));
    chk("busy16", 64'(busy16), 64'(m16.left > 0));
    chk("done16", 64'(done16), 64'(m16.done));
    chk("cnt16",  64'(cnt16),  64'(m16.cnt));
    chk("out8",   64'(out8),   m8.r);
    chk("ser8",   64'(ser8),   64'(m8.r[7]));
    chk("busy8",  64'(busy8),  64'(m8.left > 0));
    chk("done8",  64'(done8),  64'(m8.done));
    chk("cnt8",   64'(cnt8),   64'(m8.cnt));
  endtask

  initial begin
    logic [15:0] pat;
    int run16, run8;
    bit pd16, pd8;
    pat = 16'hA5C3;

    // Initial reset.
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;

    // Some activity then a 2-cycle reset in the middle of a serialize.
    en = 1'b1; mode = 3'd6; ld = 16'h1234; cyc();
    en = 1'b0; start = 1'b1; ld = 16'hBEEF; cyc();
    start = 1'b0; cyc(); cyc();
    reset = 1'b1; cyc(); cyc();
    reset = 1'b0;
    chk("rst_out", 64'(out16), 64'd0);
    chk("rst_cnt", 64'(cnt16), 64'd0);
    chk("rst_busy", 64'(busy16), 64'd0);
    chk("rst_done", 64'(done16), 64'd0);

    // Manual ops on a known value.
    en = 1'b1; mode = 3'd6; ld = 16'h8001; cyc();
    mode = 3'd3; cyc(); chk("rol", 64'(out16), 64'h0003);
    mode = 3'd4; cyc(); chk("ror", 64'(out16), 64'h8001);
    mode = 3'd5; cyc(); chk("asr", 64'(out16), 64'hC000);
    mode = 3'd1; sl = 1'b1; cyc(); chk("shl", 64'(out16), 64'h8001);
    mode = 3'd2; sr = 1'b0; cyc(); chk("shr", 64'(out16), 64'h4000);
    chk("cnt5", 64'(cnt16), 64'd5);

    // Counter saturation.
    mode = 3'd6; ld = 16'hFFFF; cyc();
    mode = 3'd1; sl = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (i == 16) chk("shl16_zero", 64'(out16), 64'd0);
      chk("cnt_sat16", 64'(cnt16), 64'((i > 16) ? 16 : i));
      chk("cnt_sat8", 64'(cnt8), 64'((i > 8) ? 8 : i));
    end

    // Serializer on a known word.
    en = 1'b0; sl = 1'b0; ld = pat; start = 1'b1; cyc();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("ser_bit", 64'(ser16), 64'(pat[15-i]));
      chk("ser_busy", 64'(busy16), 64'd1);
      chk("ser_nodone", 64'(done16), 64'd0);
      cyc();
    end
    chk("ser_done", 64'(done16), 64'd1);
    chk("ser_busy_off", 64'(busy16), 64'd0);
    chk("ser_out0", 64'(out16), 64'd0);
    cyc();
    chk("done_pulse", 64'(done16), 64'd0);

    // Manual ops ignored while busy, then reset aborts at shift 7.
    ld = pat; start = 1'b1; cyc();
    start = 1'b0; en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      mode = (i % 2 == 0) ? 3'd7 : 3'd6;
      ld = 16'($urandom);
      chk("ign_bit", 64'(ser16), 64'(pat[15-i]));
      cyc();
    end
    reset = 1'b1; en = 1'b0; cyc();
    reset = 1'b0;
    chk("abort_out", 64'(out16), 64'd0);
    chk("abort_busy", 64'(busy16), 64'd0);
    chk("abort_done", 64'(done16), 64'd0);
    cyc();
    chk("abort_nodone", 64'(done16), 64'd0);

    // start held high: back-to-back serializes on both widths.
    ld = pat; start = 1'b1;
    run16 = 0; run8 = 0; pd16 = 1'b0; pd8 = 1'b0;
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (pd16) chk("b2b16", 64'(busy16), 64'd1);
      if (pd8)  chk("b2b8", 64'(busy8), 64'd1);
      if (busy16) run16++;
      else if (run16 != 0) begin chk("run16", 64'(run16), 64'd16); run16 = 0; end
      if (busy8) run8++;
      else if (run8 != 0) begin chk("run8", 64'(run8), 64'd8); run8 = 0; end
      pd16 = done16; pd8 = done8;
    end
    start = 1'b0;
    for (int i = 0; i < 20; i++) cyc();

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      reset = ($urandom_range(0, 60) == 0);
      start = ($urandom_range(0, 12) == 0);
      en    = 1'($urandom);
      mode  = 3'($urandom);
      sl    = 1'($urandom);
      sr    = 1'($urandom);
      ld    = 16'($urandom);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
